// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between two requesters: registers the winner's
// operands, drives the ALU for one cycle, then holds the result until the owner accepts it.
module alu_arbiter #(
    parameter logic FAIR = 1'b1
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        Req0Valid,
    output logic        Req0Ready,
    input  logic [31:0] Req0OpA,
    input  logic [31:0] Req0OpB,
    input  logic [31:0] Req0ExtImm,
    input  logic [2:0]  Req0ALUFunc,
    input  logic        Req0OpBSrc,
    input  logic        Req1Valid,
    output logic        Req1Ready,
    input  logic [31:0] Req1OpA,
    input  logic [31:0] Req1OpB,
    input  logic [31:0] Req1ExtImm,
    input  logic [2:0]  Req1ALUFunc,
    input  logic        Req1OpBSrc,
    output logic        Resp0Valid,
    input  logic        Resp0Ready,
    output logic [31:0] Resp0Result,
    output logic        Resp0Zero,
    output logic        Resp1Valid,
    input  logic        Resp1Ready,
    output logic [31:0] Resp1Result,
    output logic        Resp1Zero,
    output logic [31:0] AluOpA,
    output logic [31:0] AluOpB,
    output logic [31:0] AluExtImm,
    output logic [2:0]  AluFunc,
    output logic        AluOpBSrc,
    input  logic [31:0] AluResult,
    input  logic        AluZero,
    output logic        Busy,
    output logic [1:0]  state_dbg
);

    // Handshakes: a transfer happens on a rising edge where Valid && Ready are
    // both high; Ready never depends on anything but state, pointer and Valid.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic        ptr, owner, grant, accept, resp_hs;
    logic [31:0] op_a, op_b, ext_imm, res;
    logic [2:0]  func;
    logic        opb_src, zero;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        grant     = Req1Valid;
        accept    = 1'b0;
        resp_hs   = 1'b0;
        Req0Ready = 1'b0;
        Req1Ready = 1'b0;
        if (Req0Valid && Req1Valid) grant = FAIR ? ptr : 1'b0;
        case (state)
            IDLE: begin
                Req0Ready = rstn && !grant && Req0Valid;
                Req1Ready = rstn && grant && Req1Valid;
                accept    = Req0Ready || Req1Ready;
                if (accept) state_nxt = EXEC;
            end
            EXEC: state_nxt = RESP;
            RESP: begin
                resp_hs = owner ? Resp1Ready : Resp0Ready;
                if (resp_hs) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ptr     <= 1'b0;
            owner   <= 1'b0;
            op_a    <= '0;
            op_b    <= '0;
            ext_imm <= '0;
            func    <= '0;
            opb_src <= 1'b0;
            res     <= '0;
            zero    <= 1'b0;
        end else begin
            if (accept) begin
                owner   <= grant;
                op_a    <= grant ? Req1OpA     : Req0OpA;
                op_b    <= grant ? Req1OpB     : Req0OpB;
                ext_imm <= grant ? Req1ExtImm  : Req0ExtImm;
                func    <= grant ? Req1ALUFunc : Req0ALUFunc;
                opb_src <= grant ? Req1OpBSrc  : Req0OpBSrc;
            end
            if (state == EXEC) begin
                res  <= AluResult;
                zero <= AluZero;
            end
            // The requester just served loses the next tie.
            if (resp_hs && FAIR) ptr <= ~owner;
        end
    end

    assign Resp0Valid  = (state == RESP) && !owner;
    assign Resp1Valid  = (state == RESP) && owner;
    assign Resp0Result = res;
    assign Resp1Result = res;
    assign Resp0Zero   = zero;
    assign Resp1Zero   = zero;
    assign AluOpA      = op_a;
    assign AluOpB      = op_b;
    assign AluExtImm   = ext_imm;
    assign AluFunc     = func;
    assign AluOpBSrc   = opb_src;
    assign Busy        = (state != IDLE);
    assign state_dbg   = state;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: a round-robin and a fixed-priority instance share stimulus,
// each checked every cycle against a transaction-level model, plus directed scenarios.
module tb_alu_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstn;
    logic        req0_valid, req1_valid, resp0_ready, resp1_ready;
    logic [31:0] req0_op_a, req0_op_b, req0_imm, req1_op_a, req1_op_b, req1_imm;
    logic [2:0]  req0_func, req1_func;
    logic        req0_src, req1_src;

    logic        req0_ready [2];
    logic        req1_ready [2];
    logic        resp0_valid [2];
    logic        resp1_valid [2];
    logic        resp0_zero [2];
    logic        resp1_zero [2];
    logic        busy [2];
    logic        alu_src [2];
    logic        alu_zero [2];
    logic [31:0] resp0_result [2];
    logic [31:0] resp1_result [2];
    logic [31:0] alu_op_a [2];
    logic [31:0] alu_op_b [2];
    logic [31:0] alu_imm [2];
    logic [31:0] alu_result [2];
    logic [2:0]  alu_func [2];
    logic [1:0]  state_dbg [2];

    int tests = 0;
    int fails = 0;
    logic [0:0] exp_q [$];

    task automatic check(input string name, input int inst, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s[%0d] at %0t: got %0h expected %0h", name, inst, $time, act, exp);
        end
    endtask

    // Reference ALU: func 101 reports zero=1 regardless of result, so a
    // recomputed zero flag is distinguishable from a forwarded one.
    function automatic logic [32:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                           input logic [31:0] imm, input logic [2:0] f, input logic src);
        logic [31:0] bb;
        logic [31:0] r;
        bb = src ? imm : b;
        case (f)
            3'b000:  r = a & bb;
            3'b001:  r = a | bb;
            3'b010:  r = a + bb;
            3'b110:  r = a - bb;
            3'b111:  r = {31'd0, $signed(a) < $signed(bb)};
            default: r = a ^ bb;
        endcase
        return {(f == 3'b101) ? 1'b1 : (r == 32'd0), r};
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_inst
        localparam logic FAIR_G = (g == 0);

        alu_arbiter #(.FAIR(FAIR_G)) u_dut (
            .clk(clk), .rstn(rstn),
            .Req0Valid(req0_valid), .Req0Ready(req0_ready[g]), .Req0OpA(req0_op_a), .Req0OpB(req0_op_b),
            .Req0ExtImm(req0_imm), .Req0ALUFunc(req0_func), .Req0OpBSrc(req0_src),
            .Req1Valid(req1_valid), .Req1Ready(req1_ready[g]), .Req1OpA(req1_op_a), .Req1OpB(req1_op_b),
            .Req1ExtImm(req1_imm), .Req1ALUFunc(req1_func), .Req1OpBSrc(req1_src),
            .Resp0Valid(resp0_valid[g]), .Resp0Ready(resp0_ready), .Resp0Result(resp0_result[g]), .Resp0Zero(resp0_zero[g]),
            .Resp1Valid(resp1_valid[g]), .Resp1Ready(resp1_ready), .Resp1Result(resp1_result[g]), .Resp1Zero(resp1_zero[g]),
            .AluOpA(alu_op_a[g]), .AluOpB(alu_op_b[g]), .AluExtImm(alu_imm[g]), .AluFunc(alu_func[g]),
            .AluOpBSrc(alu_src[g]), .AluResult(alu_result[g]), .AluZero(alu_zero[g]),
            .Busy(busy[g]), .state_dbg(state_dbg[g])
        );

        assign {alu_zero[g], alu_result[g]} = alu_fn(alu_op_a[g], alu_op_b[g], alu_imm[g], alu_func[g], alu_src[g]);

        // Model: one operation in flight at most; m_exec marks its ALU cycle.
        logic        m_act, m_exec, m_own, m_pref, m_src, m_z;
        logic [31:0] m_a, m_b, m_imm, m_res;
        logic [2:0]  m_fn;
        logic        m_win, m_rdy0, m_rdy1;

        always_comb begin
            m_win  = (req0_valid && req1_valid) ? (FAIR_G ? m_pref : 1'b0) : req1_valid;
            m_rdy0 = rstn && !m_act && !m_win && req0_valid;
            m_rdy1 = rstn && !m_act && m_win && req1_valid;
        end

        always @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                m_act <= 1'b0; m_exec <= 1'b0; m_own <= 1'b0; m_pref <= 1'b0;
                m_a <= '0; m_b <= '0; m_imm <= '0; m_fn <= '0; m_src <= 1'b0;
                m_res <= '0; m_z <= 1'b0;
            end else if (!m_act) begin
                if (m_rdy0 || m_rdy1) begin
                    m_act  <= 1'b1;
                    m_exec <= 1'b1;
                    m_own  <= m_rdy1;
                    m_a    <= m_rdy1 ? req1_op_a : req0_op_a;
                    m_b    <= m_rdy1 ? req1_op_b : req0_op_b;
                    m_imm  <= m_rdy1 ? req1_imm  : req0_imm;
                    m_fn   <= m_rdy1 ? req1_func : req0_func;
                    m_src  <= m_rdy1 ? req1_src  : req0_src;
                end
            end else if (m_exec) begin
                {m_z, m_res} <= alu_fn(m_a, m_b, m_imm, m_fn, m_src);
                m_exec       <= 1'b0;
            end else if (m_own ? resp1_ready : resp0_ready) begin
                m_act <= 1'b0;
                if (FAIR_G) m_pref <= ~m_own;
            end
        end

        always @(negedge clk) begin
            if (rstn) begin
                check("busy",   g, busy[g], m_act);
                check("dbg",    g, state_dbg[g] != 2'd0, m_act);
                check("rdy0",   g, req0_ready[g], m_rdy0);
                check("rdy1",   g, req1_ready[g], m_rdy1);
                check("rvld0",  g, resp0_valid[g], m_act && !m_exec && !m_own);
                check("rvld1",  g, resp1_valid[g], m_act && !m_exec && m_own);
                check("rres0",  g, resp0_result[g], m_res);
                check("rres1",  g, resp1_result[g], m_res);
                check("rzero0", g, resp0_zero[g], m_z);
                check("rzero1", g, resp1_zero[g], m_z);
                check("alu_a",  g, alu_op_a[g], m_a);
                check("alu_b",  g, alu_op_b[g], m_b);
                check("alu_i",  g, alu_imm[g], m_imm);
                check("alu_f",  g, alu_func[g], m_fn);
                check("alu_s",  g, alu_src[g], m_src);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        @(posedge clk);
        #2;
        rstn = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0; resp0_ready = 1'b0; resp1_ready = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rstn = 1'b1;
    endtask

    task automatic rand_ops();
        req0_op_a = ($urandom_range(0, 1) != 0) ? $urandom : $urandom_range(0, 3);
        req0_op_b = ($urandom_range(0, 1) != 0) ? $urandom : $urandom_range(0, 3);
        req0_imm  = ($urandom_range(0, 1) != 0) ? $urandom : $urandom_range(0, 3);
        req0_func = 3'($urandom_range(0, 7));
        req0_src  = 1'($urandom_range(0, 1));
        req1_op_a = ($urandom_range(0, 1) != 0) ? $urandom : $urandom_range(0, 3);
        req1_op_b = ($urandom_range(0, 1) != 0) ? $urandom : $urandom_range(0, 3);
        req1_imm  = ($urandom_range(0, 1) != 0) ? $urandom : $urandom_range(0, 3);
        req1_func = 3'($urandom_range(0, 7));
        req1_src  = 1'($urandom_range(0, 1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [32:0] exp_rz;
        logic        found;
        int          last_k, fp_grants, fp_r1;

        rstn = 1'b0;
        rand_ops();
        req0_valid = 1'b1; req1_valid = 1'b0; resp0_ready = 1'b0; resp1_ready = 1'b0;
        #12;
        for (int i = 0; i < 2; i++) begin
            check("rst_rdy0", i, req0_ready[i], 0);
            check("rst_busy", i, busy[i], 0);
            check("rst_rvld", i, resp0_valid[i] | resp1_valid[i], 0);
            check("rst_alu",  i, alu_op_a[i], 0);
            check("rst_res",  i, resp0_result[i], 0);
        end
        req0_valid = 1'b0;
        @(posedge clk);
        #1;
        rstn = 1'b1;

        // Single op: 5 + 3 from requester 0
        apply_reset();
        req0_op_a = 32'd5; req0_op_b = 32'd3; req0_imm = 32'd0; req0_func = 3'b010; req0_src = 1'b0;
        req0_valid = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 2; i++) check("one_rdy0", i, req0_ready[i], 1);
        cyc();
        req0_valid = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check("one_alu_a", i, alu_op_a[i], 5);
            check("one_busy",  i, busy[i], 1);
            check("one_early", i, resp0_valid[i], 0);
        end
        cyc();
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check("one_rvld0", i, resp0_valid[i], 1);
            check("one_res",   i, resp0_result[i], 8);
            check("one_zero",  i, resp0_zero[i], 0);
            check("one_rvld1", i, resp1_valid[i], 0);
        end
        cyc();
        resp0_ready = 1'b1;
        @(negedge clk);
        cyc();
        @(negedge clk);
        for (int i = 0; i < 2; i++) check("one_done", i, busy[i], 0);

        // Both requesters continuously valid, responses always accepted
        apply_reset();
        rand_ops();
        req0_valid = 1'b1; req1_valid = 1'b1; resp0_ready = 1'b1; resp1_ready = 1'b1;
        exp_q = '{1'b0, 1'b1, 1'b0, 1'b1};
        last_k = -1; fp_grants = 0; fp_r1 = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (req0_ready[0] || req1_ready[0]) begin
                if (exp_q.size() == 0) check("rr_extra", 0, 1, 0);
                else check("rr_order", 0, req1_ready[0], exp_q.pop_front());
                if (last_k >= 0) check("rr_gap", 0, k - last_k, 3);
                last_k = k;
            end
            if (req0_ready[1]) fp_grants++;
            if (req1_ready[1]) fp_r1++;
            cyc();
            rand_ops();
        end
        check("rr_left", 0, exp_q.size(), 0);
        check("fp_grants", 1, fp_grants, 4);
        check("fp_r1", 1, fp_r1, 0);

        // Back-pressure on requester 1's response
        apply_reset();
        rand_ops();
        exp_rz = alu_fn(req1_op_a, req1_op_b, req1_imm, req1_func, req1_src);
        req1_valid = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            @(negedge clk);
            if (resp1_valid[0]) found = 1'b1;
            else cyc();
        end
        check("bp_wait", 0, found, 1);
        cyc();
        req1_valid = 1'b0; req0_valid = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                check("bp_rvld", i, resp1_valid[i], 1);
                check("bp_res",  i, resp1_result[i], exp_rz[31:0]);
                check("bp_zero", i, resp1_zero[i], exp_rz[32]);
                check("bp_busy", i, busy[i], 1);
                check("bp_rdy0", i, req0_ready[i], 0);
            end
            cyc();
        end
        resp1_ready = 1'b1;
        @(negedge clk);
        cyc();
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check("bp_idle", i, busy[i], 0);
            check("bp_next", i, req0_ready[i], 1);
        end
        cyc();
        req0_valid = 1'b0;

        // Reset asserted during EXEC
        apply_reset();
        rand_ops();
        req0_valid = 1'b1;
        @(negedge clk);
        cyc();
        req1_valid = 1'b1;
        #2;
        rstn = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            check("mr_busy", i, busy[i], 0);
            check("mr_rdy",  i, req0_ready[i] | req1_ready[i], 0);
            check("mr_rvld", i, resp0_valid[i] | resp1_valid[i], 0);
            check("mr_alu",  i, alu_op_a[i] | alu_op_b[i] | alu_imm[i], 0);
            check("mr_func", i, alu_func[i], 0);
            check("mr_res",  i, resp0_result[i], 0);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(posedge clk);
        #1;
        rstn = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) check("mr_norsp", i, resp0_valid[i] | resp1_valid[i] | busy[i], 0);
            cyc();
        end
        req0_valid = 1'b1; req1_valid = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check("mr_g0", i, req0_ready[i], 1);
            check("mr_g1", i, req1_ready[i], 0);
        end
        cyc();
        req0_valid = 1'b0; req1_valid = 1'b0; resp0_ready = 1'b1;

        // Requester 1 pulses Valid while requester 0 waits in RESP
        apply_reset();
        rand_ops();
        req0_valid = 1'b1;
        @(negedge clk);
        cyc();
        req0_valid = 1'b0;
        @(negedge clk);
        cyc();
        req1_valid = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 2; i++) check("st_rdy1", i, req1_ready[i], 0);
        cyc();
        req1_valid = 1'b0;
        @(negedge clk);
        cyc();
        resp0_ready = 1'b1;
        @(negedge clk);
        cyc();
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                check("st_none", i, req1_ready[i] | resp1_valid[i], 0);
                check("st_idle", i, busy[i], 0);
            end
            cyc();
        end

        // Randomized traffic
        for (int k = 0; k < 1500; k++) begin
            if (k == 750) apply_reset();
            rand_ops();
            req0_valid  = ($urandom_range(0, 3) != 0);
            req1_valid  = ($urandom_range(0, 3) != 0);
            resp0_ready = ($urandom_range(0, 2) != 0);
            resp1_ready = ($urandom_range(0, 2) != 0);
            cyc();
        end

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
